// File: rtl/mem_stage_if.sv
// EX->MEM handshake, data-memory bus and writeback bundle for the memory stage.
// slave is the stage's view; master is the surrounding pipeline/memory side.
interface mem_stage_if;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] ALU_result;
  logic [31:0] rdata2;
  logic [2:0]  funct3;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic [4:0]  rd;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic [31:0] wb_data;
  logic        misalign_err;

  modport slave (
    input  valid_in, ALU_result, rdata2, funct3, MemRead, MemWrite, MemtoReg,
           RegWrite, rd, dmem_rdata, dmem_ack,
    output ready_in, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_rd, wb_RegWrite, wb_data, misalign_err
  );

  modport master (
    output valid_in, ALU_result, rdata2, funct3, MemRead, MemWrite, MemtoReg,
           RegWrite, rd, dmem_rdata, dmem_ack,
    input  ready_in, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_rd, wb_RegWrite, wb_data, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: single-outstanding data-memory access with lane
// alignment, load extension, misalignment faulting and a registered writeback bundle.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q;
  logic        dmem_req_q, dmem_we_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_be_q;
  logic        wb_valid_q, wb_regwrite_q, misalign_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  // Context of the outstanding access, needed to shape the response
  logic [2:0]  funct3_q;
  logic [1:0]  lo_q;
  logic        is_load_q, regwrite_q;
  logic [4:0]  rd_q;

  logic        mem_op, is_store, fault_d;
  logic [1:0]  lo;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, load_d;
  logic        unused_ok;

  assign bus.ready_in     = (state_q == IDLE) && rst_n;
  assign bus.dmem_req     = dmem_req_q;
  assign bus.dmem_we      = dmem_we_q;
  assign bus.dmem_addr    = dmem_addr_q;
  assign bus.dmem_wdata   = dmem_wdata_q;
  assign bus.dmem_be      = dmem_be_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_RegWrite  = wb_regwrite_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_err = misalign_q;
  assign unused_ok        = bus.MemtoReg;

  // Request-side decode; MemRead&&MemWrite is treated as a store
  always_comb begin
    mem_op   = bus.MemRead | bus.MemWrite;
    is_store = bus.MemWrite;
    lo       = bus.ALU_result[1:0];
    fault_d  = 1'b0;
    if (bus.funct3[1:0] == 2'd1 && lo[0])      fault_d = 1'b1;
    if (bus.funct3[1:0] == 2'd2 && lo != 2'd0) fault_d = 1'b1;
    if (is_store && bus.funct3 > 3'd2)         fault_d = 1'b1;
    if (!is_store && (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 || bus.funct3 == 3'd7))
      fault_d = 1'b1;
    case (bus.funct3[1:0])
      2'd0:    begin be_d = 4'b0001 << lo; wdata_d = {4{bus.rdata2[7:0]}};  end
      2'd1:    begin be_d = 4'b0011 << lo; wdata_d = {2{bus.rdata2[15:0]}}; end
      default: begin be_d = 4'b1111;       wdata_d = bus.rdata2;            end
    endcase
  end

  // Response-side lane select and extension
  always_comb begin
    shifted = bus.dmem_rdata >> {lo_q, 3'b000};
    case (funct3_q)
      3'd0:    load_d = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_d = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_d = {24'h0, shifted[7:0]};
      3'd5:    load_d = {16'h0, shifted[15:0]};
      default: load_d = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= 32'h0;
      dmem_wdata_q  <= 32'h0;
      dmem_be_q     <= 4'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
      wb_rd_q       <= 5'h0;
      wb_data_q     <= 32'h0;
      funct3_q      <= 3'h0;
      lo_q          <= 2'h0;
      is_load_q     <= 1'b0;
      regwrite_q    <= 1'b0;
      rd_q          <= 5'h0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.valid_in) begin
          if (!mem_op) begin
            wb_valid_q    <= 1'b1;
            wb_data_q     <= bus.ALU_result;
            wb_rd_q       <= bus.rd;
            wb_regwrite_q <= bus.RegWrite;
          end else if (fault_d) begin
            wb_valid_q    <= 1'b1;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= bus.rd;
            misalign_q    <= 1'b1;
          end else begin
            dmem_req_q    <= 1'b1;
            dmem_we_q     <= is_store;
            dmem_addr_q   <= {bus.ALU_result[31:2], 2'b00};
            dmem_be_q     <= be_d;
            dmem_wdata_q  <= wdata_d;
            funct3_q      <= bus.funct3;
            lo_q          <= lo;
            is_load_q     <= !is_store;
            regwrite_q    <= bus.RegWrite;
            rd_q          <= bus.rd;
            state_q       <= WAIT;
          end
        end
        WAIT: if (bus.dmem_ack) begin
          dmem_req_q    <= 1'b0;
          dmem_we_q     <= 1'b0;
          wb_valid_q    <= 1'b1;
          wb_rd_q       <= rd_q;
          wb_regwrite_q <= is_load_q && regwrite_q;
          wb_data_q     <= is_load_q ? load_d : 32'h0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
